ysyx_25040101_ifu: RTL and testbench
====================================

YSYX_25040101_IFU -- requirements
Module: ysyx_25040101_ifu

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset, SHALL be provided.
REQ-002 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  in  1  reset, synchronous, active-low; SHALL be sampled on the rising edge of clk.
REQ-004 Port imem_req_valid_o  out  1  fetch request valid.
REQ-005 Port imem_req_ready_i  in  1  memory accepts request.
REQ-006 Port imem_addr_o  out  32  fetch address, equals pc_o.
REQ-007 Port imem_resp_valid_i  in  1  fetch response valid, one-cycle pulse.
REQ-008 Port imem_resp_data_i  in  32  fetched instruction word.
REQ-009 Port imem_resp_err_i  in  1  access fault, qualified by imem_resp_valid_i.
REQ-010 Port inst_valid_o  out  1  instruction available to decode.
REQ-011 Port inst_ready_i  in  1  decode/execute retires the instruction this cycle.
REQ-012 Port dnpc_i  in  32  next PC from execute, qualified by inst_valid_o && inst_ready_i.
REQ-013 Port halt_i  in  1  ebreak retiring; qualified by the same handshake.
REQ-014 Ports inst_o 32, pc_o 32, opcode_o 7 (inst_o[6:0]), func3_o 3 (inst_o[14:12]), func7_o 1 (inst_o[30])  out  held instruction and its fields.
REQ-015 Ports halted_o 1, fault_o 1, misalign_o 1, inst_cnt_o 32  out  status and retired-instruction count.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, VALID, HALT, one-hot or binary.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 REQ: imem_req_valid_o=1, address=pc_o; stay while imem_req_ready_i=0; go to WAIT on the cycle valid&&ready.
REQ-019 imem_req_valid_o SHALL be 1 only in REQ and SHALL NOT drop before acceptance; the address SHALL be stable while it is asserted.
REQ-020 WAIT: on imem_resp_valid_i=1 with err=0, latch imem_resp_data_i into inst_o and go to VALID; with err=1, set fault_o and go to HALT.
REQ-021 imem_resp_valid_i SHALL be ignored in every state except WAIT, including a pulse in the same cycle as request acceptance.
REQ-022 VALID: inst_valid_o=1; inst_o/pc_o SHALL be held stable until handshake (inst_valid_o && inst_ready_i).
REQ-023 On handshake with halt_i=1: go to HALT, pc_o unchanged, inst_cnt_o increments.
REQ-024 On handshake with halt_i=0 and dnpc_i[1:0]=2'b00: pc_o<=dnpc_i, inst_cnt_o increments, go to REQ next cycle (min. 3 cycles per instruction with zero-wait memory).
REQ-025 On handshake with dnpc_i[1:0]!=0: set misalign_o, pc_o<=dnpc_i, inst_cnt_o increments, go to HALT, no request issued.
REQ-026 HALT is terminal until reset: halted_o=1, inst_valid_o=0, imem_req_valid_o=0.
REQ-027 inst_cnt_o SHALL wrap 32'hFFFF_FFFF -> 0 without side effects.
REQ-028 inst_ready_i/dnpc_i/halt_i SHALL be ignored outside VALID.
REQ-029 fault_o and misalign_o SHALL be sticky until reset; at most one of them set per run.
REQ-030 Outputs opcode_o/func3_o/func7_o SHALL be pure slices of the registered inst_o.

Reset
REQ-031 With rst_n=0 at a clock edge: state=IDLE, pc_o=RESET_PC, inst_o=32'h0000_0013, inst_cnt_o=0, all other outputs 0.
REQ-032 Reset mid-transaction (REQ, WAIT or VALID) SHALL abandon it; the memory is reset with the same rst_n, so no stale response is expected.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-034 Reset release, ready=1, response 1 cycle later with 32'h0010_0093 -> request at 0x8000_0000 in cycle 2, inst_valid_o in cycle 4, opcode_o=7'h13, func3_o=0.
REQ-035 imem_req_ready_i low for 5 cycles -> req_valid and addr held constant for all 6 cycles, single acceptance.
REQ-036 Retire with dnpc_i=0x8000_0004, inst_ready_i low 3 cycles first -> inst_o stable while waiting; next request addr 0x8000_0004; inst_cnt_o=1.
REQ-037 Response with err=1 -> fault_o=1, halted_o=1, no further req_valid for 20 cycles; rst_n low 1 cycle -> restart at RESET_PC.
REQ-038 Retire with halt_i=1, then with dnpc_i=0x8000_0006 in a fresh run -> first: halted_o=1, misalign_o=0; second: misalign_o=1, halted_o=1, pc_o=0x8000_0006.
REQ-039 Stray resp_valid in REQ and a force of inst_cnt to 32'hFFFF_FFFF before retire -> pulse ignored; count wraps to 0.

Source files
------------

// File: rtl/ysyx_25040101_ifu.sv
// Instruction fetch unit: issues one fetch at a time and holds the fetched word
// until decode retires it, then follows dnpc_i until a halt, fault or misaligned PC.
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        imem_resp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic [31:0] dnpc_i,
  input  logic        halt_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  func3_o,
  output logic        func7_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic        misalign_o,
  output logic [31:0] inst_cnt_o,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid, once raised, holds its payload stable and stays high until that transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic        fault_q, fault_d;
  logic        misalign_q, misalign_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP;
      inst_cnt_q <= 32'd0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_cnt_q <= inst_cnt_d;
      fault_q    <= fault_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_cnt_d = inst_cnt_q;
    fault_d    = fault_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          if (imem_resp_err_i) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            inst_d  = imem_resp_data_i;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (inst_ready_i) begin
          inst_cnt_d = inst_cnt_q + 32'd1;
          if (halt_i) begin
            state_d = S_HALT;
          end else if (dnpc_i[1:0] != 2'b00) begin
            // The bad target is still recorded so software can see where it jumped.
            pc_d       = dnpc_i;
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = dnpc_i;
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_addr_o      = pc_q;
  assign inst_valid_o     = (state_q == S_VALID);
  assign halted_o         = (state_q == S_HALT);
  assign inst_o           = inst_q;
  assign pc_o             = pc_q;
  assign opcode_o         = inst_q[6:0];
  assign func3_o          = inst_q[14:12];
  assign func7_o          = inst_q[30];
  assign fault_o          = fault_q;
  assign misalign_o       = misalign_q;
  assign inst_cnt_o       = inst_cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Testbench for ysyx_25040101_ifu: scenario tasks plus randomized fetch/retire
// traffic checked against a PC/count model and an expected-address queue.
module tb_ysyx_25040101_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        imem_resp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] dnpc_i;
  logic        halt_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  func3_o;
  logic        func7_o;
  logic        halted_o;
  logic        fault_o;
  logic        misalign_o;
  logic [31:0] inst_cnt_o;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model: expected fetch addresses, the held instruction and retire count.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;

  ysyx_25040101_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i(imem_resp_data_i), .imem_resp_err_i(imem_resp_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .dnpc_i(dnpc_i), .halt_i(halt_i), .inst_o(inst_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .func3_o(func3_o), .func7_o(func7_o),
    .halted_o(halted_o), .fault_o(fault_o), .misalign_o(misalign_o),
    .inst_cnt_o(inst_cnt_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = 32'h0;
    imem_resp_err_i   = 1'b0;
    inst_ready_i      = 1'b0;
    dnpc_i            = 32'h0;
    halt_i            = 1'b0;
  endtask

  // Leaves the bench in the single IDLE cycle right after reset release.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    clear_inputs();
    repeat (cycles) step();
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    m_pc   = RESET_PC;
    m_inst = 32'h0000_0013;
    m_cnt  = 32'h0;
  endtask

  task automatic fetch(input int ready_wait, input int resp_wait,
                       input logic [31:0] data, input logic err, input logic stray);
    logic [31:0] a;
    a = exp_q.pop_front();
    for (int i = 0; i < 8 && imem_req_valid_o !== 1'b1; i++) step();
    checks++;
    if (imem_req_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout got=%0b exp=1", imem_req_valid_o);
      return;
    end
    for (int i = 0; i <= ready_wait; i++) begin
      checks++;
      if ({imem_req_valid_o, imem_addr_o, inst_valid_o} !== {1'b1, a, 1'b0}) begin
        failures++;
        $display("FAIL req_hold got=%0b/%08h exp=1/%08h", imem_req_valid_o, imem_addr_o, a);
      end
      imem_resp_valid_i = stray & ($urandom_range(0, 1) == 1);
      imem_resp_data_i  = ~data;
      inst_ready_i      = $urandom_range(0, 1);
      imem_req_ready_i  = (i == ready_wait);
      if (i == ready_wait) imem_resp_valid_i = stray;
      step();
    end
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      checks++;
      if ({imem_req_valid_o, inst_valid_o, halted_o} !== 3'b000) begin
        failures++;
        $display("FAIL wait_state got=%03b exp=000",
                 {imem_req_valid_o, inst_valid_o, halted_o});
      end
      inst_ready_i = $urandom_range(0, 1);
      halt_i       = $urandom_range(0, 1);
      step();
    end
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = data;
    imem_resp_err_i   = err;
    step();
    clear_inputs();
    if (err) begin
      checks++;
      if ({halted_o, fault_o, misalign_o, inst_valid_o, imem_req_valid_o} !== 5'b11000) begin
        failures++;
        $display("FAIL fault_resp got=%05b exp=11000",
                 {halted_o, fault_o, misalign_o, inst_valid_o, imem_req_valid_o});
      end
    end else begin
      m_pc   = a;
      m_inst = data;
      checks++;
      if ({inst_valid_o, inst_o, pc_o, halted_o} !== {1'b1, data, a, 1'b0}) begin
        failures++;
        $display("FAIL fetch_data got=%0b/%08h/%08h exp=1/%08h/%08h",
                 inst_valid_o, inst_o, pc_o, data, a);
      end
      checks++;
      if ({opcode_o, func3_o, func7_o} !== {data[6:0], data[14:12], data[30]}) begin
        failures++;
        $display("FAIL fields got=%02h/%0h/%0b exp=%02h/%0h/%0b",
                 opcode_o, func3_o, func7_o, data[6:0], data[14:12], data[30]);
      end
    end
  endtask

  task automatic retire(input int ready_wait, input logic [31:0] dnpc, input logic halt);
    for (int i = 0; i < ready_wait; i++) begin
      checks++;
      if ({inst_valid_o, inst_o, pc_o} !== {1'b1, m_inst, m_pc}) begin
        failures++;
        $display("FAIL valid_hold got=%0b/%08h/%08h exp=1/%08h/%08h",
                 inst_valid_o, inst_o, pc_o, m_inst, m_pc);
      end
      dnpc_i = $urandom;
      halt_i = $urandom_range(0, 1);
      step();
    end
    inst_ready_i = 1'b1;
    dnpc_i       = dnpc;
    halt_i       = halt;
    step();
    clear_inputs();
    m_cnt = m_cnt + 32'd1;
    checks++;
    if (inst_cnt_o !== m_cnt) begin
      failures++;
      $display("FAIL inst_cnt got=%08h exp=%08h", inst_cnt_o, m_cnt);
    end
    if (halt) begin
      checks++;
      if ({halted_o, misalign_o, fault_o, pc_o, inst_valid_o, imem_req_valid_o} !==
          {3'b100, m_pc, 2'b00}) begin
        failures++;
        $display("FAIL halt_retire got=%0b%0b%0b/%08h exp=100/%08h",
                 halted_o, misalign_o, fault_o, pc_o, m_pc);
      end
    end else if (dnpc[1:0] != 2'b00) begin
      m_pc = dnpc;
      checks++;
      if ({halted_o, misalign_o, fault_o, pc_o, inst_valid_o, imem_req_valid_o} !==
          {3'b110, dnpc, 2'b00}) begin
        failures++;
        $display("FAIL misalign_retire got=%0b%0b%0b/%08h exp=110/%08h",
                 halted_o, misalign_o, fault_o, pc_o, dnpc);
      end
    end else begin
      checks++;
      if ({halted_o, misalign_o, fault_o, imem_req_valid_o, imem_addr_o} !==
          {4'b0001, dnpc}) begin
        failures++;
        $display("FAIL next_req got=%0b%0b%0b%0b/%08h exp=0001/%08h",
                 halted_o, misalign_o, fault_o, imem_req_valid_o, imem_addr_o, dnpc);
      end
      exp_q.push_back(dnpc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({imem_req_valid_o, inst_valid_o, halted_o, fault_o, misalign_o, pc_o, inst_o, inst_cnt_o}
        !== {5'b00000, RESET_PC, 32'h0000_0013, 32'h0}) begin
      failures++;
      $display("FAIL %s got=%05b/%08h/%08h/%08h exp=00000/%08h/00000013/00000000", name,
               {imem_req_valid_o, inst_valid_o, halted_o, fault_o, misalign_o},
               pc_o, inst_o, inst_cnt_o, RESET_PC);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    rst_n = 1'b0;
    imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b1; inst_ready_i = 1'b1; halt_i = 1'b1;
    step();
    check_reset_outputs("reset_state");
    checks++;
    if ({opcode_o, func3_o, func7_o} !== {7'h13, 3'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_fields got=%02h/%0h/%0b exp=13/0/0", opcode_o, func3_o, func7_o);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    do_reset(2);
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_cycle got=%0b exp=0", imem_req_valid_o);
    end
    step();
    checks++;
    if ({imem_req_valid_o, imem_addr_o} !== {1'b1, RESET_PC}) begin
      failures++;
      $display("FAIL cycle2_req got=%0b/%08h exp=1/%08h", imem_req_valid_o, imem_addr_o, RESET_PC);
    end
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0010_0093;
    step();
    clear_inputs();
    checks++;
    if ({inst_valid_o, opcode_o, func3_o, inst_o} !== {1'b1, 7'h13, 3'h0, 32'h0010_0093}) begin
      failures++;
      $display("FAIL cycle4_valid got=%0b/%02h/%0h exp=1/13/0", inst_valid_o, opcode_o, func3_o);
    end
    void'(exp_q.pop_front());
    m_pc   = RESET_PC;
    m_inst = 32'h0010_0093;
    retire(3, 32'h8000_0004, 1'b0);
    fetch(5, 0, 32'h0020_0113, 1'b0, 1'b0);
  endtask

  task automatic test_fault();
    do_reset(1);
    fetch(1, 2, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready_i  = $urandom_range(0, 1);
      imem_resp_valid_i = $urandom_range(0, 1);
      inst_ready_i      = $urandom_range(0, 1);
      step();
      checks++;
      if ({imem_req_valid_o, inst_valid_o, halted_o, fault_o, misalign_o} !== 5'b00110) begin
        failures++;
        $display("FAIL fault_sticky got=%05b exp=00110",
                 {imem_req_valid_o, inst_valid_o, halted_o, fault_o, misalign_o});
      end
    end
    do_reset(1);
    check_reset_outputs("fault_restart");
    fetch(0, 0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_halt_and_misalign();
    do_reset(1);
    fetch(0, 1, 32'h0010_0073, 1'b0, 1'b0);
    retire(1, 32'h8000_0004, 1'b1);
    for (int i = 0; i < 5; i++) begin
      imem_req_ready_i = 1'b1; inst_ready_i = 1'b1;
      step();
      checks++;
      if ({halted_o, imem_req_valid_o, inst_valid_o, inst_cnt_o} !== {3'b100, 32'd1}) begin
        failures++;
        $display("FAIL halt_terminal got=%03b/%0d exp=100/1",
                 {halted_o, imem_req_valid_o, inst_valid_o}, inst_cnt_o);
      end
    end
    do_reset(1);
    fetch(2, 0, $urandom, 1'b0, 1'b1);
    retire(0, 32'h8000_0006, 1'b0);
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    step();
    imem_req_ready_i = 1'b1;
    rst_n = 1'b0;
    step();
    check_reset_outputs("reset_in_req");
    do_reset(1);
    fetch(0, 0, $urandom, 1'b0, 1'b0);
    inst_ready_i = 1'b1; dnpc_i = 32'h8000_0100;
    rst_n = 1'b0;
    step();
    check_reset_outputs("reset_in_valid");
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset(1);
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.inst_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    fetch(2, 1, $urandom, 1'b0, 1'b1);
    retire(0, RESET_PC + 32'd8, 1'b0);
    fetch(0, 0, $urandom, 1'b0, 1'b1);
    retire(1, RESET_PC + 32'd12, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    do_reset(1);
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, $urandom_range(0, 1));
      d = $urandom;
      if (n != 39) d[1:0] = 2'b00;
      else if (d[1:0] == 2'b00) d[1:0] = 2'b10;
      retire($urandom_range(0, 2), d, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_fault();
    test_halt_and_misalign();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
